// File: rtl/alu_sequencer.sv
// Instruction sequencer in front of an 8-bit combinational ALU: a 4x8 register file,
// registered ALU operands and select, ALU result/flags sampled and then written back.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_instr,
  output logic        done,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_over,
  output logic [3:0]  flags,
  input  logic [1:0]  rd_addr,
  output logic [7:0]  rd_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, WB} state_t;

  state_t          state, state_nx;
  logic [3:0][7:0] regs;
  logic [7:0]      result_q;
  logic [3:0]      flag_q;
  logic [1:0]      rd_q;
  logic            ldi_q;
  logic            accept;

  wire       i_ldi = cmd_instr[15];
  wire [2:0] i_op  = cmd_instr[14:12];
  wire [1:0] i_rd  = cmd_instr[11:10];
  wire [1:0] i_ra  = cmd_instr[9:8];
  wire [1:0] i_rb  = cmd_instr[7:6];
  wire [7:0] i_imm = cmd_instr[7:0];

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign rd_data   = regs[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = i_ldi ? WB : ISSUE;
      ISSUE:   state_nx = CAPT;
      CAPT:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '0;
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      alu_sel  <= 3'b111;
      flags    <= 4'b0000;
      done     <= 1'b0;
      result_q <= 8'h00;
      flag_q   <= 4'b0000;
      rd_q     <= 2'd0;
      ldi_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          rd_q  <= i_rd;
          ldi_q <= i_ldi;
          if (i_ldi) begin
            result_q <= i_imm;
          end else begin
            // operands read at issue, so rd aliasing ra/rb is harmless
            alu_a   <= regs[i_ra];
            alu_b   <= regs[i_rb];
            alu_sel <= i_op;
          end
        end
        CAPT: begin
          result_q <= alu_out;
          flag_q   <= {alu_carry, alu_zero, alu_neg, alu_over};
        end
        WB: begin
          regs[rd_q] <= result_q;
          if (!ldi_q) flags <= flag_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + random bench for alu_sequencer; a bench-side ALU drives the ALU inputs and
// a register-file/flags reference model predicts architectural state.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_instr;
  logic        done;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry, alu_zero, alu_neg, alu_over;
  logic [3:0]  flags;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_r [4];
  logic [3:0] m_f;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr), .done(done), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_over(alu_over), .flags(flags), .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Bench ALU: returns {carry, zero, neg, over, result}
  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = {1'b0, a} + {1'b0, b};
    c = 1'b0;
    v = 1'b0;
    case (sel)
      3'd0: begin r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b;  c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a;
      3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r[7], v, r};
  endfunction

  always_comb begin
    logic [11:0] res;
    res = alu_f(alu_a, alu_b, alu_sel);
    {alu_carry, alu_zero, alu_neg, alu_over, alu_out} = res;
  end

  function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
    logic [2:0] junk;
    junk = 3'($urandom);
    return {1'b1, junk, rd, 2'($urandom), imm};
  endfunction

  function automatic logic [15:0] mk_op(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb);
    return {1'b0, op, rd, ra, rb, 6'($urandom)};
  endfunction

  task automatic m_exec(input logic [15:0] ins);
    logic [11:0] res;
    if (ins[15]) begin
      m_r[ins[11:10]] = ins[7:0];
    end else begin
      res = alu_f(m_r[ins[9:8]], m_r[ins[7:6]], ins[14:12]);
      m_r[ins[11:10]] = res[7:0];
      m_f = res[11:8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic check_state();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), d);
      chk($sformatf("reg%0d", i), {24'h0, d}, {24'h0, m_r[i]});
    end
    chk("flags", {28'h0, flags}, {28'h0, m_f});
  endtask

  task automatic send(input logic [15:0] ins);
    int n;
    int exp_lat;
    logic [7:0] ea, eb;
    ea = m_r[ins[9:8]];
    eb = m_r[ins[7:6]];
    exp_lat = ins[15] ? 2 : 4;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_instr = ins;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", {31'h0, (n < 20)}, 32'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_instr = 16'($urandom);
    m_exec(ins);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && !ins[15]) begin
        chk("alu_a", {24'h0, alu_a}, {24'h0, ea});
        chk("alu_b", {24'h0, alu_b}, {24'h0, eb});
        chk("alu_sel", {29'h0, alu_sel}, {29'h0, ins[14:12]});
      end
      if (!done) chk("busy_ready", {31'h0, cmd_ready}, 32'h0);
    end while (!done && n < 20);
    chk("done_latency", n, exp_lat);
    check_state();
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] stream [3];
    int acc [3];
    int idx, ndone, d1;

    reset = 1'b1; cmd_valid = 1'b0; cmd_instr = 16'h0; rd_addr = 2'd0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_f = 4'b0000;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {31'h0, cmd_ready}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_alu_a", {24'h0, alu_a}, 32'h0);
    chk("rst_alu_b", {24'h0, alu_b}, 32'h0);
    chk("rst_alu_sel", {29'h0, alu_sel}, 32'h7);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, cmd_ready}, 32'h1);
    check_state();

    // ADD overflow into sign bit
    send(mk_ldi(2'd0, 8'h7F));
    send(mk_ldi(2'd1, 8'h01));
    send(mk_op(3'd0, 2'd2, 2'd0, 2'd1));
    read_reg(2'd2, d);
    chk("add_r2", {24'h0, d}, 32'h80);
    chk("add_flags", {28'h0, flags}, 32'b0011);

    // ADD wrap to zero, then LDI must not touch flags
    send(mk_ldi(2'd0, 8'hFF));
    send(mk_ldi(2'd1, 8'h01));
    send(mk_op(3'd0, 2'd3, 2'd0, 2'd1));
    read_reg(2'd3, d);
    chk("wrap_r3", {24'h0, d}, 32'h00);
    chk("wrap_flags", {28'h0, flags}, 32'b1100);
    send(mk_ldi(2'd3, 8'h55));
    read_reg(2'd3, d);
    chk("ldi_r3", {24'h0, d}, 32'h55);
    chk("ldi_keeps_flags", {28'h0, flags}, 32'b1100);

    // SUB R2 = R1 - R1
    send(mk_op(3'd1, 2'd2, 2'd1, 2'd1));
    read_reg(2'd2, d);
    chk("sub_r2", {24'h0, d}, 32'h00);
    chk("sub_flags", {28'h0, flags}, 32'b0100);

    // SHL then SHR
    send(mk_ldi(2'd0, 8'h81));
    send(mk_op(3'd5, 2'd1, 2'd0, 2'd2));
    read_reg(2'd1, d);
    chk("shl_r1", {24'h0, d}, 32'h02);
    send(mk_op(3'd6, 2'd1, 2'd1, 2'd3));
    read_reg(2'd1, d);
    chk("shr_r1", {24'h0, d}, 32'h01);

    // Handshake: cmd_valid held across a stream of 3 ALU ops
    for (int i = 0; i < 3; i++)
      stream[i] = mk_op(3'($urandom_range(0, 6)), 2'($urandom), 2'($urandom), 2'($urandom));
    idx = 0; ndone = 0; d1 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin ndone++; if (ndone == 1) d1 = c; end
      if (idx < 3) begin cmd_valid = 1'b1; cmd_instr = stream[idx]; end
      else begin cmd_valid = 1'b0; cmd_instr = 16'($urandom); end
      if (cmd_valid && cmd_ready) begin
        acc[idx] = c;
        m_exec(stream[idx]);
        idx++;
      end
    end
    chk("hs_accepts", idx, 3);
    chk("hs_dones", ndone, 3);
    chk("hs_spacing", acc[1] - acc[0], 4);
    chk("hs_second_on_done", acc[1], d1);
    check_state();

    // Reset in CAPT abandons the ADD into R2
    send(mk_ldi(2'd2, 8'h33));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_instr = mk_op(3'd0, 2'd2, 2'd0, 2'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_low_in_reset", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_f = 4'b0000;
    #1;
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_sel", {29'h0, alu_sel}, 32'h7);
    chk("midrst_ready", {31'h0, cmd_ready}, 32'h1);
    read_reg(2'd2, d);
    chk("midrst_r2", {24'h0, d}, 32'h00);
    check_state();
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_done", {31'h0, done}, 32'h0);
    end

    // Random mix of LDI and ALU ops against the reference model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0)
        send(mk_ldi(2'($urandom), 8'($urandom)));
      else
        send(mk_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
